// File: rtl/seg_scan_n.sv
// seg_scan_n: multiplexed hex seven-segment scanner with shadowed (tear-free) display data.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset
//   en         scan enable; when low the scan freezes and all segments are dark
//   data       DIGITS hex nibbles, digit 0 in the least significant nibble
//   dp         per-digit decimal-point request
//   blank      per-digit force-dark request
//   lz_en      leading-zero suppression enable
//   upd        request to capture data/dp/blank/lz_en into the shadow registers
//   seg        registered segment drive, bit 7 = dp, bits 6..0 = g..a
//   del        registered binary index of the lit digit
//   upd_ack    one-cycle pulse when the shadow capture happens
//   frame_done one-cycle pulse when del wraps back to 0
module seg_scan_n #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned DIV            = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  localparam int unsigned SEL_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blank,
  input  logic                lz_en,
  input  logic                upd,
  output logic [7:0]          seg,
  output logic [SEL_W-1:0]    del,
  output logic                upd_ack,
  output logic                frame_done
);

  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [7:0]  SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  // Active-high g..a pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    del_q, del_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic                sh_lz_q, sh_lz_d;
  logic [7:0]          seg_q, seg_d;
  logic                ack_q, ack_d;
  logic                fd_q, fd_d;

  logic       tick, last, wrap, req, cap;
  logic       hi_zero, dig_dp, dig_blank, dig_sup;
  logic [3:0] dig_nib;
  logic [7:0] seg_on;

  always_comb begin
    tick = en && (cnt_q == CNT_W'(DIV - 1));
    last = (del_q == SEL_W'(DIGITS - 1));
    wrap = tick && last;
    // An upd arriving on the wrap tick itself is captured at that wrap.
    req  = pend_q | upd;
    cap  = req & (wrap | ~en);

    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    del_d = del_q;
    if (tick) begin
      del_d = last ? '0 : del_q + SEL_W'(1);
    end

    pend_d     = req & ~cap;
    sh_data_d  = cap ? data  : sh_data_q;
    sh_dp_d    = cap ? dp    : sh_dp_q;
    sh_blank_d = cap ? blank : sh_blank_q;
    sh_lz_d    = cap ? lz_en : sh_lz_q;

    // Decode the digit that will be lit next cycle from the next shadow state, so the first
    // digit after a capture already shows the new values. hi_zero walks down from the top
    // nibble to find the leading-zero run.
    hi_zero   = 1'b1;
    dig_nib   = 4'h0;
    dig_dp    = 1'b0;
    dig_blank = 1'b0;
    dig_sup   = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (sh_data_d[4*i +: 4] == 4'h0);
      if (del_d == SEL_W'(i)) begin
        dig_nib   = sh_data_d[4*i +: 4];
        dig_dp    = sh_dp_d[i];
        dig_blank = sh_blank_d[i];
        dig_sup   = hi_zero && (i != 0);
      end
    end

    if (dig_blank) begin
      seg_on = 8'h00;
    end else if (sh_lz_d && dig_sup) begin
      seg_on = {dig_dp, 7'h00};
    end else begin
      seg_on = {dig_dp, hex7(dig_nib)};
    end

    if (en) begin
      seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
    end else begin
      seg_d = SEG_OFF;
    end

    ack_d = cap;
    fd_d  = wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      del_q      <= '0;
      pend_q     <= 1'b0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '1;
      sh_lz_q    <= 1'b0;
      seg_q      <= SEG_OFF;
      ack_q      <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      del_q      <= del_d;
      pend_q     <= pend_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sh_lz_q    <= sh_lz_d;
      seg_q      <= seg_d;
      ack_q      <= ack_d;
      fd_q       <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign del        = del_q;
  assign upd_ack    = ack_q;
  assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_n.md
SEG_SCAN_N -- requirements
Module: seg_scan_n

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits (1..16).
REQ-002 Parameter DIV, default 1000: clk cycles each digit is held (>=1).
REQ-003 Parameter SEG_ACTIVE_LOW, default 1: 1 inverts all of seg.
REQ-004 Derived SEL_W = max(1, clog2(DIGITS)).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 en  in  1  scan enable.
REQ-008 data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 least significant.
REQ-009 dp  in  DIGITS  decimal-point request per digit.
REQ-010 blank  in  DIGITS  force-dark request per digit.
REQ-011 lz_en  in  1  leading-zero suppression enable.
REQ-012 upd  in  1  request to capture data/dp/blank/lz_en into shadow registers.
REQ-013 seg  out  8  segment drive; bit7 = dp, bits6..0 = g..a.
REQ-014 del  out  SEL_W  binary index of the lit digit.
REQ-015 upd_ack  out  1  one-cycle pulse when the shadow capture occurs.
REQ-016 frame_done  out  1  one-cycle pulse when del wraps DIGITS-1 -> 0.

Function
REQ-017 Prescaler counts 0..DIV-1 while en=1; tick at DIV-1, then wraps to 0; DIV=1 ticks every cycle.
REQ-018 On tick, del advances by 1; at DIGITS-1 it wraps to 0 and frame_done pulses in the same cycle del becomes 0.
REQ-019 DIGITS=1: del constant 0; frame_done pulses on every tick.
REQ-020 upd sets a pending flag; capture occurs on the frame wrap tick, or on the next cycle if en=0; upd_ack pulses on the capture cycle and pending clears.
REQ-021 upd asserted in the same cycle as the wrap tick is captured at that wrap; upd held high captures at most once per frame.
REQ-022 Displayed digits come only from shadow registers; input changes mid-frame do not alter the current frame (no tearing).
REQ-023 seg and del are registered and change in the same cycle; the first digit shown after a capture uses the new shadow values.
REQ-024 Hex decode (active-high, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 seg[7] = shadow dp of the lit digit.
REQ-026 Shadow blank set: all 8 segment bits off, including dp.
REQ-027 Shadow lz_en=1: digit i>0 whose nibble and all higher nibbles are 0 shows segments off except dp; digit 0 is never suppressed.
REQ-028 en=0: prescaler and del hold; seg all off; frame_done 0; on re-enable, scan resumes from the held count.
REQ-029 SEG_ACTIVE_LOW=1: seg = bitwise NOT of the active-high value, so "off" = 8'hFF.

Reset
REQ-030 rst=0 at a clk edge: prescaler 0, del 0, pending 0, shadow data 0, shadow dp 0, shadow blank all 1, shadow lz_en 0.
REQ-031 Outputs during and after reset until first capture: seg off (8'hFF active-low), del 0, upd_ack 0, frame_done 0.
REQ-032 Reset mid-frame or with an update pending discards the pending update; no upd_ack pulse results.

Verification (DIGITS=4, DIV=4, SEG_ACTIVE_LOW=1)
REQ-033 rst low 2 cycles -> seg=8'hFF, del=0, upd_ack=0, frame_done=0; after release with en=1, del steps 0,1,2,3,0 every 4 cycles and frame_done pulses every 16 cycles.
REQ-034 data=16'h12AF, dp=4'b0010, blank=0, upd pulse -> upd_ack at next wrap; then del0 seg=8'h8E, del1 seg=8'h08, del2 seg=8'hA4, del3 seg=8'hF9, each held 4 cycles.
REQ-035 data=16'h0030, lz_en=1, captured -> del3 and del2 seg=8'hFF, del1 seg=8'hB0, del0 seg=8'hC0.
REQ-036 Change data to 16'h5555 with upd while del=1 -> del2, del3 keep old values in that frame; upd_ack at wrap; next frame shows all digits seg=8'h92.
REQ-037 en=0 at del=2, prescaler count 1 -> seg=8'hFF, del stays 2; en=1 -> del 2 held 2 more cycles, then 3.
REQ-038 rst low at del=3 with upd pending -> next cycle reset values; no upd_ack pulse until a new upd.
